bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Two-requester round-robin arbiter that shares one single-port synchronous block RAM (cs/we/address/data_in/data_out, one-cycle registered read) between two masters. It accepts at most one command per cycle, registers the winning command onto the RAM port and returns read data to the issuing master with an rvalid strobe. It sits directly in front of the generic sync RAM instance, and each master sees a simple req/gnt port.

## Interface
- DATA_WIDTH, 8, data bus width; must match the RAM.
- ADDR_WIDTH, 8, address width; must match the RAM.

- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- m0_req  input  1  master 0 command request.
- m0_we  input  1  master 0 write enable (1 = write, 0 = read).
- m0_addr  input  ADDR_WIDTH  master 0 address.
- m0_wdata  input  DATA_WIDTH  master 0 write data.
- m0_gnt  output  1  master 0 command accepted this cycle (combinational).
- m0_rvalid  output  1  master 0 read data valid (registered).
- m0_rdata  output  DATA_WIDTH  master 0 read data; equals ram_data_out.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- ram_cs  output  1  RAM chip select (registered).
- ram_we  output  1  RAM write enable (registered).
- ram_address  output  ADDR_WIDTH  RAM address (registered).
- ram_data_in  output  DATA_WIDTH  RAM write data (registered).
- ram_data_out  input  DATA_WIDTH  RAM read data. Valid the cycle after the RAM samples cs=1.

## Operation
- State:
  - prio: 1 bit. 0 means m0 wins a tie; reset value 0.
  - Command register: ram_* outputs.
  - Response tag pipeline: valid/id/read, stage A then stage B.
- Grant (combinational, forced 0 while rst_n=0):
  - Only one req high: that master is granted.
  - Both req high: the master selected by prio is granted.
  - Never more than one gnt high per cycle.
- Transfer happens when mX_req && mX_gnt. The master may change or drop its fields in the next cycle. There is no stall when gnt=0; the master holds req and its fields until granted.
- prio update on each transfer: prio <= ~id of the granted master. With no transfer, prio holds.
- Command register on each edge:
  - Transfer: ram_cs=1, ram_we=mX_we, ram_address=mX_addr, ram_data_in=mX_wdata.
  - Otherwise: ram_cs=0, ram_we=0; address and data hold their last values.
- Tag pipeline:
  - Stage A captures {transfer, id, ~we}.
  - Stage B captures stage A.
  - mX_rvalid = B.valid && B.read && B.id==X.
- Writes produce no response.
- m0_rdata and m1_rdata are both wired to ram_data_out. They are meaningful only while the matching rvalid is high.
- Address and data pass through unchanged; the block performs no arithmetic.

## Timing
- Cycle N: req high and gnt high (transfer).
- N+1: ram_cs=1 with the command on the RAM port; the RAM samples it at the end of N+1.
- N+2: for a read, mX_rvalid=1 and ram_data_out carries mem[addr]. Read latency from transfer to rvalid is 2 cycles.
- Throughput is 1 command per cycle. Back-to-back transfers give back-to-back rvalid in the same order.
- Same-address write at N, then read at N+1: the read returns the new data, because the RAM sequences them in separate cycles.
- Reset values while rst_n=0, sampled at posedge:
  - ram_cs=0, ram_we=0, ram_address=0, ram_data_in=0.
  - m0_gnt=0, m1_gnt=0, m0_rvalid=0, m1_rvalid=0.
  - prio=0; tag pipeline cleared.
- Reset mid-operation: in-flight reads are dropped and no rvalid is issued for them. The first cycle after release accepts requests with m0 priority.
- Simultaneous requests: grants alternate strictly m0, m1, m0, … while both hold req.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with both req=1. Required: all gnt=0, rvalid=0, ram_cs=0. After release, m0 is granted first.
- Single master write then read: m0 writes 0xA5 to addr 0x10, then reads 0x10 on the next cycle. Required:
  - ram_cs=1, we=1 one cycle after the write grant.
  - m0_rvalid=1 with m0_rdata=0xA5 two cycles after the read grant.
  - m1_rvalid stays 0.
- Contention: both masters request reads continuously, m0 at addr 0x01 (data 0x11) and m1 at addr 0x02 (data 0x22), for 6 cycles. Required: grants alternate m0, m1, m0…; rvalid alternates with 0x11 and 0x22, each 2 cycles after its grant.
- Priority memory: m1 alone for 1 transfer, then both request. Required: m0 wins the next tie.
- Idle gaps: random sparse requests. Required:
  - ram_cs=0 in every cycle following a no-transfer cycle.
  - No rvalid for writes.
  - Response count equals read-transfer count.
- Reset mid-flight: issue an m1 read, then assert rst_n=0 one cycle later. Required: m1_rvalid never asserts for that read; normal operation resumes after release.

Source files
------------

// File: rtl/bram_arbiter.sv
// Two-master round-robin front end for a single-port synchronous RAM.
// Registers the winning command onto the RAM port and tags reads so data returns to the issuer.
module bram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  logic                  prio;
  logic                  xfer;
  logic                  xfer_id;
  logic                  xfer_we;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_wdata;
  logic                  vld_p1, id_p1, rd_p1;
  logic                  vld_p2, id_p2, rd_p2;

  // p0: combinational grant; prio picks the winner only on a tie
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        m0_gnt = ~prio;
        m1_gnt = prio;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign xfer       = m0_gnt | m1_gnt;
  assign xfer_id    = m1_gnt;
  assign xfer_we    = m1_gnt ? m1_we    : m0_we;
  assign xfer_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign xfer_wdata = m1_gnt ? m1_wdata : m0_wdata;

  // p1: command register on the RAM port plus tag stage A
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio        <= 1'b0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      vld_p1      <= 1'b0;
      id_p1       <= 1'b0;
      rd_p1       <= 1'b0;
      vld_p2      <= 1'b0;
      id_p2       <= 1'b0;
      rd_p2       <= 1'b0;
    end else begin
      ram_cs <= xfer;
      ram_we <= xfer & xfer_we;
      if (xfer) begin
        prio        <= ~xfer_id;
        ram_address <= xfer_addr;
        ram_data_in <= xfer_wdata;
      end
      vld_p1 <= xfer;
      id_p1  <= xfer_id;
      rd_p1  <= ~xfer_we;
      // p2: tag stage B lines up with the RAM's registered read data
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
      rd_p2  <= rd_p1;
    end
  end

  assign m0_rvalid = vld_p2 & rd_p2 & ~id_p2;
  assign m1_rvalid = vld_p2 & rd_p2 &  id_p2;
  assign m0_rdata  = ram_data_out;
  assign m1_rdata  = ram_data_out;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: queued master commands, a simple RAM, and a scoreboard
// that predicts grants, RAM port contents and read responses from the arbitration rules.
module tb_bram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       ram_cs, ram_we;
  logic [7:0] ram_address, ram_data_in;
  logic [7:0] ram_data_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    int         gap;
  } cmd_t;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         due;
  } rsp_t;

  cmd_t q0[$];
  cmd_t q1[$];
  rsp_t sb[$];

  logic [7:0] mem [256];
  logic [7:0] shadow [256];

  bram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Generic single-port sync RAM with one-cycle registered read
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    ram_data_out = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_address] <= ram_data_in;
      else        ram_data_out     <= mem[ram_address];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input int m, input logic we, input logic [7:0] addr,
                          input logic [7:0] data, input int gap);
    cmd_t c;
    c.we = we; c.addr = addr; c.data = data; c.gap = gap;
    if (m == 0) q0.push_back(c);
    else        q1.push_back(c);
  endtask

  // Master drivers: hold a command until granted, then move to the next one
  logic t0, t1;
  initial begin
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
    forever begin
      @(negedge clk);
      t0 = m0_req && m0_gnt;
      t1 = m1_req && m1_gnt;
      @(posedge clk);
      #1;
      if (t0) void'(q0.pop_front());
      if (t1) void'(q1.pop_front());
      m0_req = 1'b0;
      if (q0.size() > 0 && q0[0].gap > 0) q0[0].gap = q0[0].gap - 1;
      else if (q0.size() > 0) begin
        m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].data;
      end
      m1_req = 1'b0;
      if (q1.size() > 0 && q1[0].gap > 0) q1[0].gap = q1[0].gap - 1;
      else if (q1.size() > 0) begin
        m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].data;
      end
    end
  end

  // Reference model: last_winner=1 after reset means m0 takes the first tie
  logic       last_winner = 1'b1;
  logic       exp_cs = 1'b0, exp_we = 1'b0;
  logic [7:0] exp_addr = 8'h00, exp_data = 8'h00;

  always @(negedge clk) begin
    logic eg0, eg1, id;
    rsp_t r;
    if (cyc > 0) begin
      chk("rvalid_both", {31'd0, m0_rvalid && m1_rvalid}, 32'd0);
      if (m0_rvalid || m1_rvalid) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", {31'd0, m1_rvalid}, 32'hDEAD);
        end else begin
          r = sb.pop_front();
          chk("rsp_id", {31'd0, m1_rvalid}, {31'd0, r.id});
          chk("rsp_cycle", cyc, r.due);
          chk("rsp_data", {24'd0, (r.id ? m1_rdata : m0_rdata)}, {24'd0, r.data});
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        r = sb.pop_front();
        chk("rsp_missing", 32'd0, {31'd0, r.id} + 32'd1);
      end
      chk("ram_cs", {31'd0, ram_cs}, {31'd0, exp_cs});
      chk("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
      chk("ram_address", {24'd0, ram_address}, {24'd0, exp_addr});
      chk("ram_data_in", {24'd0, ram_data_in}, {24'd0, exp_data});
    end
    if (!rst_n) begin
      eg0 = 1'b0; eg1 = 1'b0;
    end else if (m0_req && m1_req) begin
      eg0 = (last_winner == 1'b1); eg1 = ~eg0;
    end else begin
      eg0 = m0_req; eg1 = m1_req;
    end
    chk("grant", {30'd0, m1_gnt, m0_gnt}, {30'd0, eg1, eg0});
    if (!rst_n) begin
      sb.delete();
      last_winner = 1'b1;
      exp_cs = 1'b0; exp_we = 1'b0; exp_addr = 8'h00; exp_data = 8'h00;
    end else if (eg0 || eg1) begin
      id = eg1;
      last_winner = id;
      exp_cs   = 1'b1;
      exp_we   = id ? m1_we : m0_we;
      exp_addr = id ? m1_addr : m0_addr;
      exp_data = id ? m1_wdata : m0_wdata;
      if (exp_we) shadow[exp_addr] = exp_data;
      else begin
        r.id = id; r.data = shadow[exp_addr]; r.due = cyc + 2;
        sb.push_back(r);
      end
    end else begin
      exp_cs = 1'b0; exp_we = 1'b0;
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= budget) chk({name, "_timeout"}, n, 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    // Reset with both masters requesting; m0 must win first after release
    push_cmd(0, 1'b0, 8'h05, 8'h00, 0);
    push_cmd(1, 1'b0, 8'h06, 8'h00, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_drain("reset", 50);

    // m0 write then read of the same address on consecutive grants
    push_cmd(0, 1'b1, 8'h10, 8'hA5, 0);
    push_cmd(0, 1'b0, 8'h10, 8'h00, 0);
    wait_drain("wr_rd", 50);

    // Contention: preload then continuous reads from both masters
    push_cmd(0, 1'b1, 8'h01, 8'h11, 0);
    push_cmd(1, 1'b1, 8'h02, 8'h22, 0);
    for (int i = 0; i < 3; i++) begin
      push_cmd(0, 1'b0, 8'h01, 8'h00, 0);
      push_cmd(1, 1'b0, 8'h02, 8'h00, 0);
    end
    wait_drain("contention", 60);

    // Priority memory: m1 alone once, then a tie that m0 must win
    push_cmd(1, 1'b0, 8'h02, 8'h00, 0);
    wait_drain("m1_alone", 50);
    push_cmd(0, 1'b0, 8'h01, 8'h00, 0);
    push_cmd(1, 1'b0, 8'h02, 8'h00, 0);
    wait_drain("prio_tie", 50);

    // Random sparse traffic over a small address window
    for (int i = 0; i < 150; i++) begin
      push_cmd(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
               8'($urandom), $urandom_range(0, 3));
      push_cmd(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
               8'($urandom), $urandom_range(0, 3));
    end
    wait_drain("random", 3000);

    // Reset one cycle after an m1 read transfer: that response must vanish
    push_cmd(1, 1'b0, 8'h33, 8'h00, 0);
    n = 0;
    while (q1.size() > 0 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50) chk("midflight_timeout", n, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    push_cmd(0, 1'b0, 8'h01, 8'h00, 0);
    push_cmd(1, 1'b0, 8'h02, 8'h00, 0);
    wait_drain("after_reset", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
